// File: rtl/cart_rom_mapper.sv
// MegaROM bank-switching engine: decodes CPU writes into bank registers and
// translates CPU reads into ROM-image fetches over a request/ack memory port.
package cart_rom_mapper_pkg;
  typedef enum logic [2:0] {
    MAPPER_UNUSED     = 3'd0,
    MAPPER_NONE       = 3'd1,
    MAPPER_KONAMI     = 3'd2,
    MAPPER_KONAMI_SCC = 3'd3,
    MAPPER_ASCII8     = 3'd4,
    MAPPER_ASCII16    = 3'd5
  } mapper_typ_t;
endpackage

module cart_rom_mapper
  import cart_rom_mapper_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mapper_typ_t mapper,
  input  logic [26:0] rom_size,
  input  logic [3:0]  offset,
  input  logic        cs,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  output logic [26:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        scc_cs
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q, state_d;
  logic [3:0][7:0]   bank_q, bank_d;
  mapper_typ_t       mapper_q;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic [26:0]       mem_addr_q, mem_addr_d;
  logic              scc_cs_q, scc_cs_d;

  logic        rd_req, wr_req;
  logic        banked_win, scc_hit;
  logic [1:0]  page8;
  logic [7:0]  sel8, sel16;
  logic [15:0] none_base;
  logic [26:0] xlat_addr;
  logic        xlat_ok;

  function automatic logic [3:0][7:0] bank_init(input mapper_typ_t m);
    if (m == MAPPER_KONAMI || m == MAPPER_KONAMI_SCC) begin
      return {8'd3, 8'd2, 8'd1, 8'd0};
    end
    return '0;
  endfunction

  assign rd_req     = cs & cpu_rd;
  assign wr_req     = cs & cpu_wr;
  assign banked_win = (cpu_addr[15:14] == 2'b01) || (cpu_addr[15:14] == 2'b10);
  // 4000/6000/8000/A000 map to pages 0..3 via address bits 15 and 13.
  assign page8      = {cpu_addr[15], cpu_addr[13]};
  assign sel8       = bank_q[page8];
  assign sel16      = cpu_addr[15] ? bank_q[1] : bank_q[0];
  assign none_base  = {offset, 12'h000};
  assign scc_hit    = (mapper == MAPPER_KONAMI_SCC) && (cpu_addr[15:11] == 5'b10011) &&
                      (bank_q[2][5:0] == 6'h3f);

  always_comb begin
    xlat_addr = '0;
    xlat_ok   = 1'b0;
    case (mapper)
      MAPPER_NONE: begin
        xlat_ok   = (cpu_addr >= none_base);
        xlat_addr = {11'b0, cpu_addr - none_base};
      end
      MAPPER_KONAMI, MAPPER_KONAMI_SCC, MAPPER_ASCII8: begin
        xlat_ok   = banked_win;
        xlat_addr = {6'b0, sel8, cpu_addr[12:0]};
      end
      MAPPER_ASCII16: begin
        xlat_ok   = banked_win;
        xlat_addr = {5'b0, sel16, cpu_addr[13:0]};
      end
      default: ;
    endcase
    if (xlat_addr >= rom_size || scc_hit) begin
      xlat_ok = 1'b0;
    end
  end

  always_comb begin
    bank_d = bank_q;
    if (wr_req && !scc_hit) begin
      case (mapper)
        MAPPER_KONAMI: begin
          if (cpu_addr[15:13] inside {3'b011, 3'b100, 3'b101}) bank_d[page8] = cpu_din;
        end
        MAPPER_KONAMI_SCC: begin
          // Registers sit in the 2 KB slice at x000-x7FF of the upper half of each page.
          if (banked_win && cpu_addr[12:11] == 2'b10) bank_d[page8] = cpu_din;
        end
        MAPPER_ASCII8: begin
          if (cpu_addr[15:13] == 3'b011) bank_d[cpu_addr[12:11]] = cpu_din;
        end
        MAPPER_ASCII16: begin
          if (cpu_addr[15:13] == 3'b011 && !cpu_addr[11]) bank_d[{1'b0, cpu_addr[12]}] = cpu_din;
        end
        default: ;
      endcase
    end
    if (mapper != mapper_q) begin
      bank_d = bank_init(mapper);
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    cpu_dout_d = cpu_dout_q;
    scc_cs_d   = scc_hit && (wr_req || (rd_req && state_q == StIdle));
    case (state_q)
      StIdle: begin
        if (rd_req) begin
          if (xlat_ok) begin
            mem_addr_d = xlat_addr;
            state_d    = StReq;
          end else begin
            cpu_dout_d = 8'hff;
          end
        end
      end
      StReq:  state_d = StWait;
      StWait: begin
        if (mem_ack) begin
          cpu_dout_d = mem_data;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bank_q     <= bank_init(mapper);
      mapper_q   <= mapper;
      cpu_dout_q <= 8'hff;
      mem_addr_q <= '0;
      scc_cs_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      mapper_q   <= mapper;
      cpu_dout_q <= cpu_dout_d;
      mem_addr_q <= mem_addr_d;
      scc_cs_q   <= scc_cs_d;
    end
  end

  assign cpu_dout = cpu_dout_q;
  assign cpu_wait = (state_q != StIdle);
  assign mem_addr = mem_addr_q;
  assign mem_rd   = (state_q == StReq);
  assign scc_cs   = scc_cs_q;

endmodule
